// File: rtl/matrix_pkg.sv
// Shared types, default geometry and timing helpers for the LED matrix scan engine.
package matrix_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SHIFT_COL = 3'd2,
    SHIFT_ROW = 3'd3,
    LATCH     = 3'd4,
    DISPLAY   = 3'd5
  } state_t;

  localparam int unsigned DEF_ROWS     = 16;
  localparam int unsigned DEF_COLS     = 16;
  localparam int unsigned DEF_PWM_BITS = 2;

  localparam int unsigned NSUB = (32'd1 << DEF_PWM_BITS) - 32'd1;
  localparam int unsigned XW   = $clog2(DEF_COLS);
  localparam int unsigned YW   = $clog2(DEF_ROWS);

  function automatic int unsigned nsub_of(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 32'd1;
  endfunction

  // Cycles from one LOAD to the next: load, column shift, row shift, latch, dwell.
  function automatic int unsigned slot_cycles(input int unsigned cols,
                                              input int unsigned clkdiv,
                                              input int unsigned dwell);
    return 32'd1 + 32'd2 * clkdiv * (cols + 32'd1) + clkdiv + dwell;
  endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Pixel read port plus shift-register pads between the scan engine and the matrix.
interface matrix_scan_driver_if #(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned PWM_BITS = 2
);
  localparam int unsigned X_W = $clog2(COLS);
  localparam int unsigned Y_W = $clog2(ROWS);

  logic [X_W-1:0]      pix_x;
  logic [Y_W-1:0]      pix_y;
  logic [PWM_BITS-1:0] pix_level;
  logic                RCLK;
  logic                RSDI;
  logic                CCLK;
  logic                CSDI;
  logic                LE;
  logic                OEB;

  modport master (
    output pix_x, pix_y, RCLK, RSDI, CCLK, CSDI, LE, OEB,
    input  pix_level
  );

  modport slave (
    input  pix_x, pix_y, RCLK, RSDI, CCLK, CSDI, LE, OEB,
    output pix_level
  );
endinterface

// File: rtl/serial_phase_gen.sv
// CLKDIV divider: strobes the end of the low phase (rise) and of the high phase (done).
module serial_phase_gen #(
  parameter int unsigned CLKDIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic rise_c,
  output logic done_c
);
  localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DW-1:0] cnt;
  logic          high;
  logic          end_c;

  assign end_c  = run && (cnt == DW'(CLKDIV - 1));
  assign rise_c = end_c && !high;
  assign done_c = end_c && high;

  // Restarts at the low phase whenever run drops, so each shift starts aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      high <= 1'b0;
    end else if (end_c) begin
      cnt  <= '0;
      high <= ~high;
    end else begin
      cnt <= cnt + DW'(1);
    end
  end
endmodule

// File: rtl/matrix_scan_driver.sv
// Row-slot scan engine: shift columns, step the one-hot row, latch, then dwell with OEB low.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int unsigned ROWS           = 16,
  parameter int unsigned COLS           = 16,
  parameter int unsigned PWM_BITS       = 2,
  parameter int unsigned CLKDIV         = 1,
  parameter int unsigned DWELL          = 64,
  parameter bit          COL_ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  matrix_scan_driver_if.master bus,
  output logic                 frame_start,
  output logic                 busy
);
  localparam int unsigned N_SUB   = nsub_of(PWM_BITS);
  localparam int unsigned X_W     = $clog2(COLS);
  localparam int unsigned Y_W     = $clog2(ROWS);
  localparam int unsigned CNT_MAX = (DWELL > COLS) ? DWELL : COLS;
  localparam int unsigned C_W     = $clog2(CNT_MAX + 1);

  state_t              state;
  logic [Y_W-1:0]      row;
  logic [PWM_BITS-1:0] sub;
  logic [C_W-1:0]      cnt;
  logic                run_c;
  logic                rise_c;
  logic                done_c;
  logic                row_last_c;
  logic [Y_W-1:0]      row_next_c;
  logic [PWM_BITS-1:0] sub_next_c;
  logic                col_bit_c;

  assign bus.pix_y = row;
  assign run_c     = (state == SHIFT_COL) || (state == SHIFT_ROW) || (state == LATCH);
  assign col_bit_c = (bus.pix_level > sub) ^ COL_ACTIVE_LOW;

  serial_phase_gen #(.CLKDIV(CLKDIV)) u_phase (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (run_c),
    .rise_c (rise_c),
    .done_c (done_c)
  );

  // Row/subframe successor used at the end of every dwell.
  always_comb begin
    row_last_c = (row == Y_W'(ROWS - 1));
    row_next_c = row_last_c ? '0 : row + Y_W'(1);
    sub_next_c = sub;
    if (row_last_c) begin
      sub_next_c = (sub == PWM_BITS'(N_SUB - 1)) ? '0 : sub + PWM_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      row         <= '0;
      sub         <= '0;
      cnt         <= '0;
      bus.pix_x   <= '0;
      bus.RCLK    <= 1'b0;
      bus.RSDI    <= 1'b0;
      bus.CCLK    <= 1'b0;
      bus.CSDI    <= 1'b0;
      bus.LE      <= 1'b0;
      bus.OEB     <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state       <= LOAD;
            bus.pix_x   <= X_W'(COLS - 1);
            bus.RSDI    <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          state    <= SHIFT_COL;
          bus.CSDI <= col_bit_c;
          cnt      <= '0;
        end
        // Address moves on CCLK rise; the next column is captured on CCLK fall.
        SHIFT_COL: begin
          if (rise_c) begin
            bus.CCLK <= 1'b1;
            if (bus.pix_x != '0) begin
              bus.pix_x <= bus.pix_x - X_W'(1);
            end
          end
          if (done_c) begin
            bus.CCLK <= 1'b0;
            if (cnt == C_W'(COLS - 1)) begin
              state <= SHIFT_ROW;
            end else begin
              cnt      <= cnt + C_W'(1);
              bus.CSDI <= col_bit_c;
            end
          end
        end
        SHIFT_ROW: begin
          if (rise_c) begin
            bus.RCLK <= 1'b1;
          end
          if (done_c) begin
            bus.RCLK <= 1'b0;
            bus.LE   <= 1'b1;
            state    <= LATCH;
          end
        end
        LATCH: begin
          if (rise_c) begin
            bus.LE  <= 1'b0;
            bus.OEB <= 1'b0;
            cnt     <= '0;
            state   <= DISPLAY;
          end
        end
        // en is only honoured here, so a stop request always finishes the row.
        DISPLAY: begin
          if (cnt == C_W'(DWELL - 1)) begin
            bus.OEB <= 1'b1;
            cnt     <= '0;
            if (en) begin
              state       <= LOAD;
              row         <= row_next_c;
              sub         <= sub_next_c;
              bus.pix_x   <= X_W'(COLS - 1);
              bus.RSDI    <= (row_next_c == '0);
              frame_start <= (row_next_c == '0) && (sub_next_c == '0);
            end else begin
              state    <= IDLE;
              row      <= '0;
              sub      <= '0;
              bus.RSDI <= 1'b0;
              busy     <= 1'b0;
            end
          end else begin
            cnt <= cnt + C_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Bench for matrix_scan_driver: pad-level monitor plus a pixel-rule reference model.
`timescale 1ns/1ps
module tb_matrix_scan_driver;
  import matrix_pkg::*;

  localparam int unsigned R     = 16;
  localparam int unsigned C     = 16;
  localparam int unsigned PB    = 2;
  localparam int unsigned CD    = 1;
  localparam int unsigned DW    = 64;
  localparam int unsigned NS    = nsub_of(PB);
  localparam int unsigned SLOT  = slot_cycles(C, CD, DW);
  localparam int unsigned FRAME = NS * R * SLOT;

  logic clk;
  logic reset_n;
  logic en;
  logic fs_a, busy_a, fs_b, busy_b;
  logic [PB-1:0] img [R][C];

  matrix_scan_driver_if #(.ROWS(R), .COLS(C), .PWM_BITS(PB)) bus_a ();
  matrix_scan_driver_if #(.ROWS(R), .COLS(C), .PWM_BITS(PB)) bus_b ();

  assign bus_a.pix_level = img[bus_a.pix_y][bus_a.pix_x];
  assign bus_b.pix_level = img[bus_b.pix_y][bus_b.pix_x];

  matrix_scan_driver #(.ROWS(R), .COLS(C), .PWM_BITS(PB), .CLKDIV(CD), .DWELL(DW),
                       .COL_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .bus(bus_a), .frame_start(fs_a), .busy(busy_a));

  matrix_scan_driver #(.ROWS(R), .COLS(C), .PWM_BITS(PB), .CLKDIV(CD), .DWELL(DW),
                       .COL_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .bus(bus_b), .frame_start(fs_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [C-1:0] cols_a;
    logic [C-1:0] cols_b;
    logic         rsdi;
    logic [R-1:0] rowreg;
    int           n_cclk;
    int           n_rclk;
    int           le_len;
    int           oeb_len;
    int           t_oeb;
  } slot_t;

  slot_t slots[$];
  int    fs_times[$];
  int    cyc;
  int    viol;
  int    n_tests;
  int    n_fail;

  // Pad monitor: reconstructs each row slot as the matrix hardware would see it.
  initial begin
    logic         p_cclk_a, p_cclk_b, p_rclk, p_oeb;
    logic [C-1:0] acc_a, acc_b;
    logic [R-1:0] rowreg;
    logic         rs;
    int           ncc, nrc, nle, noeb, toeb;
    slot_t        s;
    cyc = 0; viol = 0;
    p_cclk_a = 0; p_cclk_b = 0; p_rclk = 0; p_oeb = 1;
    acc_a = '0; acc_b = '0; rowreg = '0; rs = 0;
    ncc = 0; nrc = 0; nle = 0; noeb = 0; toeb = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        p_cclk_a = 0; p_cclk_b = 0; p_rclk = 0; p_oeb = 1;
        acc_a = '0; acc_b = '0; rowreg = '0; rs = 0;
        ncc = 0; nrc = 0; nle = 0; noeb = 0;
      end else begin
        if (bus_a.CCLK && !p_cclk_a) begin
          acc_a = {acc_a[C-2:0], bus_a.CSDI};
          ncc++;
        end
        if (bus_b.CCLK && !p_cclk_b) acc_b = {acc_b[C-2:0], bus_b.CSDI};
        if (bus_a.RCLK && !p_rclk) begin
          rowreg = {rowreg[R-2:0], bus_a.RSDI};
          rs = bus_a.RSDI;
          nrc++;
        end
        if (bus_a.LE) nle++;
        if (!bus_a.OEB) begin
          if (p_oeb) toeb = cyc;
          noeb++;
        end
        if (bus_a.OEB && !p_oeb) begin
          s.cols_a = acc_a; s.cols_b = acc_b; s.rsdi = rs; s.rowreg = rowreg;
          s.n_cclk = ncc; s.n_rclk = nrc; s.le_len = nle; s.oeb_len = noeb; s.t_oeb = toeb;
          slots.push_back(s);
          ncc = 0; nrc = 0; nle = 0; noeb = 0;
        end
        if (fs_a) fs_times.push_back(cyc);
        if ((bus_a.CCLK && bus_a.RCLK) || (bus_a.LE && !bus_a.OEB)) viol++;
        p_cclk_a = bus_a.CCLK; p_cclk_b = bus_b.CCLK; p_rclk = bus_a.RCLK; p_oeb = bus_a.OEB;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected column pattern for one slot straight from the level-versus-subframe rule.
  function automatic logic [C-1:0] exp_cols(input int row, input int sub, input bit inv);
    logic [C-1:0] v;
    for (int x = 0; x < C; x++) v[x] = ((int'(img[row][x]) > sub) ? 1'b1 : 1'b0) ^ inv;
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    slots.delete();
    fs_times.delete();
    viol = 0;
  endtask

  task automatic wait_slots(input int n, input string name);
    int budget;
    budget = n * SLOT + 200;
    while (slots.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (slots.size() < n) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got %0d slots, required %0d", name, slots.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [15:0] got, want;
    en = 1'b0;
    reset_n = 1'b0;
    step();
    want = {8'b0000_0100, 4'h0, 4'h0};
    got  = {bus_a.RCLK, bus_a.RSDI, bus_a.CCLK, bus_a.CSDI, bus_a.LE, bus_a.OEB, fs_a, busy_a,
            bus_a.pix_x, bus_a.pix_y};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL reset_hold: got %h required %h", got, want); end
    reset_n = 1'b1;
    slots.delete(); fs_times.delete(); viol = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      got = {bus_a.RCLK, bus_a.RSDI, bus_a.CCLK, bus_a.CSDI, bus_a.LE, bus_a.OEB, fs_a, busy_a,
             bus_a.pix_x, bus_a.pix_y};
      n_tests++;
      if (got !== want) begin
        n_fail++; $display("FAIL idle_outputs cycle %0d: got %h required %h", i, got, want);
      end
    end
    n_tests++;
    if (slots.size() != 0 || fs_times.size() != 0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_activity: got slots=%0d fs=%0d busy_b=%b required 0 0 0",
               slots.size(), fs_times.size(), busy_b);
    end
  endtask

  task automatic test_full_brightness();
    for (int y = 0; y < R; y++) for (int x = 0; x < C; x++) img[y][x] = PB'(NS);
    apply_reset();
    en = 1'b1;
    wait_slots(NS * R + 1, "full");
    for (int i = 0; i < slots.size() && i <= NS * R; i++) begin
      int row;
      row = i % R;
      n_tests++;
      if (slots[i].n_cclk != C || slots[i].n_rclk != 1 || slots[i].le_len != CD ||
          slots[i].oeb_len != DW) begin
        n_fail++;
        $display("FAIL full_counts slot %0d: got cclk=%0d rclk=%0d le=%0d oeb=%0d required %0d 1 %0d %0d",
                 i, slots[i].n_cclk, slots[i].n_rclk, slots[i].le_len, slots[i].oeb_len, C, CD, DW);
      end
      n_tests++;
      if (slots[i].cols_a !== {C{1'b1}}) begin
        n_fail++; $display("FAIL full_cols slot %0d: got %h required %h", i, slots[i].cols_a, {C{1'b1}});
      end
      n_tests++;
      if (slots[i].rsdi !== (row == 0) || slots[i].rowreg !== (R'(1) << row)) begin
        n_fail++;
        $display("FAIL row_onehot slot %0d: got rsdi=%b reg=%h required %b %h",
                 i, slots[i].rsdi, slots[i].rowreg, (row == 0), R'(1) << row);
      end
      if (i > 0) begin
        n_tests++;
        if (slots[i].t_oeb - slots[i-1].t_oeb != SLOT) begin
          n_fail++;
          $display("FAIL slot_period slot %0d: got %0d required %0d", i,
                   slots[i].t_oeb - slots[i-1].t_oeb, SLOT);
        end
      end
    end
    n_tests++;
    if (fs_times.size() < 2 || (fs_times.size() >= 2 && fs_times[1] - fs_times[0] != FRAME)) begin
      n_fail++;
      $display("FAIL frame_period: got count=%0d delta=%0d required >=2 %0d", fs_times.size(),
               (fs_times.size() >= 2) ? fs_times[1] - fs_times[0] : 0, FRAME);
    end
    n_tests++;
    if (viol != 0) begin n_fail++; $display("FAIL pad_overlap: got %0d required 0", viol); end
  endtask

  task automatic test_single_pixel();
    for (int y = 0; y < R; y++) for (int x = 0; x < C; x++) img[y][x] = '0;
    img[2][5] = PB'(1);
    apply_reset();
    en = 1'b1;
    wait_slots(NS * R, "single");
    for (int i = 0; i < slots.size() && i < NS * R; i++) begin
      logic [C-1:0] ea, eb;
      ea = exp_cols(i % R, i / R, 1'b0);
      eb = exp_cols(i % R, i / R, 1'b1);
      n_tests++;
      if (slots[i].cols_a !== ea || slots[i].cols_b !== eb) begin
        n_fail++;
        $display("FAIL single_pixel slot %0d: got a=%h b=%h required a=%h b=%h",
                 i, slots[i].cols_a, slots[i].cols_b, ea, eb);
      end
    end
  endtask

  task automatic test_random_image();
    for (int y = 0; y < R; y++) for (int x = 0; x < C; x++) img[y][x] = PB'($urandom_range(0, NS));
    apply_reset();
    en = 1'b1;
    wait_slots(NS * R, "random");
    for (int i = 0; i < slots.size() && i < NS * R; i++) begin
      logic [C-1:0] ea, eb;
      ea = exp_cols(i % R, i / R, 1'b0);
      eb = exp_cols(i % R, i / R, 1'b1);
      n_tests++;
      if (slots[i].cols_a !== ea || slots[i].cols_b !== eb) begin
        n_fail++;
        $display("FAIL random_cols slot %0d: got a=%h b=%h required a=%h b=%h",
                 i, slots[i].cols_a, slots[i].cols_b, ea, eb);
      end
    end
  endtask

  task automatic test_stop_restart();
    int budget;
    for (int y = 0; y < R; y++) for (int x = 0; x < C; x++) img[y][x] = PB'($urandom_range(0, NS));
    apply_reset();
    en = 1'b1;
    wait_slots(7, "stop_pre");
    budget = 2 * SLOT;
    while (!(bus_a.CCLK && bus_a.pix_y == 4'd7) && budget > 0) begin step(); budget--; end
    n_tests++;
    if (budget == 0) begin n_fail++; $display("FAIL stop_reach_row7: got timeout required CCLK in row 7"); end
    en = 1'b0;
    budget = 2 * SLOT;
    while (busy_a && budget > 0) begin step(); budget--; end
    n_tests++;
    if (slots.size() != 8 || busy_a !== 1'b0) begin
      n_fail++; $display("FAIL stop_slots: got %0d busy=%b required 8 0", slots.size(), busy_a);
    end
    if (slots.size() == 8) begin
      n_tests++;
      if (slots[7].oeb_len != DW || slots[7].cols_a !== exp_cols(7, 0, 1'b0)) begin
        n_fail++;
        $display("FAIL stop_last_row: got oeb=%0d cols=%h required %0d %h",
                 slots[7].oeb_len, slots[7].cols_a, DW, exp_cols(7, 0, 1'b0));
      end
    end
    repeat (20) step();
    n_tests++;
    if (slots.size() != 8 || busy_a !== 1'b0 || bus_a.OEB !== 1'b1 || bus_a.pix_y !== 4'd0) begin
      n_fail++;
      $display("FAIL stop_idle: got slots=%0d busy=%b oeb=%b y=%0d required 8 0 1 0",
               slots.size(), busy_a, bus_a.OEB, bus_a.pix_y);
    end
    en = 1'b1;
    step();
    n_tests++;
    if (fs_a !== 1'b1 || busy_a !== 1'b1 || bus_a.pix_y !== 4'd0 || bus_a.pix_x !== 4'(C - 1) ||
        bus_a.RSDI !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_load: got fs=%b busy=%b y=%0d x=%0d rsdi=%b required 1 1 0 %0d 1",
               fs_a, busy_a, bus_a.pix_y, bus_a.pix_x, bus_a.RSDI, C - 1);
    end
  endtask

  task automatic test_async_reset();
    int budget;
    logic [15:0] got, want;
    apply_reset();
    en = 1'b1;
    budget = 6 * SLOT;
    while (!(bus_a.CCLK && bus_a.pix_y == 4'd3) && budget > 0) begin step(); budget--; end
    n_tests++;
    if (budget == 0) begin n_fail++; $display("FAIL areset_reach: got timeout required CCLK in row 3"); end
    #1;
    reset_n = 1'b0;
    #1;
    want = {8'b0000_0100, 4'h0, 4'h0};
    got  = {bus_a.RCLK, bus_a.RSDI, bus_a.CCLK, bus_a.CSDI, bus_a.LE, bus_a.OEB, fs_a, busy_a,
            bus_a.pix_x, bus_a.pix_y};
    n_tests++;
    if (got !== want) begin n_fail++; $display("FAIL areset_outputs: got %h required %h", got, want); end
    repeat (3) step();
    reset_n = 1'b1;
    step();
    n_tests++;
    if (fs_a !== 1'b1 || busy_a !== 1'b1 || bus_a.pix_y !== 4'd0 || bus_a.pix_x !== 4'(C - 1) ||
        bus_a.OEB !== 1'b1 || bus_a.CCLK !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_restart: got fs=%b busy=%b y=%0d x=%0d oeb=%b cclk=%b required 1 1 0 %0d 1 0",
               fs_a, busy_a, bus_a.pix_y, bus_a.pix_x, bus_a.OEB, bus_a.CCLK, C - 1);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    en      = 1'b0;
    reset_n = 1'b0;
    for (int y = 0; y < R; y++) for (int x = 0; x < C; x++) img[y][x] = '0;
    test_reset();
    test_full_brightness();
    test_single_pixel();
    test_random_image();
    test_stop_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_scan_driver.md
# matrix_scan_driver

Parametrised scan engine for shift-register LED matrices: serialises one row of column data per row slot, advances a one-hot row register, latches, then enables the display for a programmable dwell. Adds grayscale through PWM subframes, selectable column polarity and run/stop control. Sits between the game logic, which supplies pixel levels through a combinational read port, and the RCLK/RSDI/CCLK/CSDI/LE/OEB pads.

## Interface
- ROWS, 16, matrix rows (row shift-register length), ≥2
- COLS, 16, matrix columns (column shift-register length), ≥2
- PWM_BITS, 2, bits per pixel level; NSUB = 2^PWM_BITS − 1 subframes
- CLKDIV, 1, cycles per serial-clock phase, ≥1
- DWELL, 64, cycles OEB is held low per row slot, ≥1
- COL_ACTIVE_LOW, 0, 1 = invert CSDI (column sink drivers)
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  run request
- pix_x  out  clog2(COLS)  column address being fetched
- pix_y  out  clog2(ROWS)  row address being fetched
- pix_level  in  PWM_BITS  level of (pix_x, pix_y); must be valid combinationally within the same cycle
- RCLK, RSDI  out  1  row shift clock / data
- CCLK, CSDI  out  1  column shift clock / data
- LE  out  1  latch enable, both registers
- OEB  out  1  output enable, active low
- frame_start  out  1  one-cycle pulse at the start of every frame
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, LOAD, SHIFT_COL, SHIFT_ROW, LATCH, DISPLAY.
- Reset: state IDLE; row, sub and col counters 0; all outputs 0 except OEB = 1.
- IDLE → LOAD when en = 1. frame_start pulses in the LOAD cycle of row 0, sub 0.
- LOAD (1 cycle): pix_y = row, pix_x = COLS−1; CSDI loaded from pix_level; RSDI = (row == 0).
- SHIFT_COL: COLS bit periods, columns sent COLS−1 down to 0. Each bit is CLKDIV cycles with CCLK = 0, then CLKDIV cycles with CCLK = 1.
- Column data: CSDI = (pix_level > sub) XOR COL_ACTIVE_LOW. Level 0 is always off; level NSUB is lit in every subframe.
- SHIFT_ROW: one RCLK period (CLKDIV low, CLKDIV high) shifting RSDI. Exactly one 1 enters per ROWS slots.
- LATCH: LE = 1 for CLKDIV cycles.
- DISPLAY: OEB = 0 for DWELL cycles; OEB = 1 in every other state.
- End of DISPLAY:
  - row wraps ROWS−1 → 0 and increments sub; sub wraps NSUB−1 → 0.
  - If en = 1, go to LOAD; otherwise go to IDLE with counters reset to 0.
- en is sampled only at the end of DISPLAY. Deasserting en mid-row completes the row, including its dwell.
- reset_n low at any point forces the reset values immediately. A shift in progress is abandoned, and OEB goes high asynchronously.

## Timing
- Row slot = 1 + 2·CLKDIV·(COLS+1) + CLKDIV + DWELL cycles; 100 cycles at defaults.
- Frame = NSUB·ROWS slots; 4800 cycles at defaults.
- pix_x/pix_y change on the edge where CCLK rises (and in LOAD).
- pix_level is sampled on the edge where CCLK falls; CSDI updates on that same edge. Each CSDI value is therefore stable through a full CCLK high phase.
- RSDI is stable from LOAD until after the RCLK falling edge.
- CCLK and RCLK are never high in the same cycle.
- LE is never high while OEB = 0.
- All outputs are registered; no combinational path from pix_level to the pads.

## Structure
- Package matrix_pkg holds:
  - the state enum;
  - localparams NSUB, XW = clog2(COLS), YW = clog2(ROWS);
  - the row-slot length function used by the bench.
- Sub-module serial_phase_gen: CLKDIV divider generating the low/high phase and bit-done strobes. It is shared by SHIFT_COL and SHIFT_ROW; the FSM and counters stay in matrix_scan_driver.

## Test plan
- Reset, then en = 0 for 50 cycles → OEB = 1, all other outputs 0, busy = 0, no clock edges.
- Defaults, en = 1, pix_level = 3 everywhere:
  - each row slot: 16 CCLK pulses, 1 RCLK pulse, LE high 1 cycle, OEB low 64 cycles;
  - slots are exactly 100 cycles apart;
  - frame_start pulses every 4800 cycles.
- pix_level = 1 only at (x=5, y=2), 0 elsewhere → that bit is 1 only in row 2 of sub 0; every other CSDI bit in the frame is 0. Rerun with COL_ACTIVE_LOW = 1 → the same pattern, inverted.
- RSDI check → RSDI = 1 only for row 0; the captured row register is one-hot and advances once per slot.
- Drop en during SHIFT_COL of row 7 → row 7 completes including its 64-cycle dwell, then IDLE. Re-raise en → restart at row 0, sub 0 with frame_start.
- Assert reset_n low mid-SHIFT_COL with CCLK = 1 → all outputs go to reset values in the same cycle. After release with en = 1 → LOAD of row 0 on the next cycle.
